// File: rtl/rx_logic_2_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_logic_2_if : per-port 2-phase push channels plus the node FIFO write   |
// | side. Revision: 1.0                                                        |
// +----------------------------------------------------------------------------+
interface rx_logic_2_if #(
  parameter int SIZE             = 8,
  parameter int PORT_COUNT       = 5,
  parameter int DESTINATION_BITS = 3
);
  logic [PORT_COUNT-1:0]      fifo_push_req;
  logic [PORT_COUNT-1:0]      fifo_push_ack;
  logic [PORT_COUNT*SIZE-1:0] fifo_push_data;
  logic                       fifo_write;
  logic                       fifo_full;
  logic [SIZE-1:0]            fifo_item_in;
  logic [DESTINATION_BITS-1:0] src_port;

  // Transceivers and FIFO side
  modport master (
    output fifo_push_req,
    output fifo_push_data,
    output fifo_full,
    input  fifo_push_ack,
    input  fifo_write,
    input  fifo_item_in,
    input  src_port
  );

  // Receive logic side
  modport slave (
    input  fifo_push_req,
    input  fifo_push_data,
    input  fifo_full,
    output fifo_push_ack,
    output fifo_write,
    output fifo_item_in,
    output src_port
  );
endinterface
`default_nettype wire

// File: rtl/rx_logic_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_logic_2 : arbitrates 2-phase rx channels into one FIFO write per cycle. |
// | Optional macro RX_LOGIC_RR_EN selects round-robin instead of fixed prio.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rx_logic_2 #(
  parameter int ID               = -1,
  parameter int SIZE             = 8,
  parameter int PORT_COUNT       = 5,
  parameter int DESTINATION_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  rx_logic_2_if.slave bus
);

  logic [PORT_COUNT-1:0]       w_pending;
  logic [PORT_COUNT-1:0]       w_grant_onehot;
  logic [PORT_COUNT-1:0]       r_ack;
  logic [SIZE-1:0]             w_slice [PORT_COUNT];
  logic [SIZE-1:0]             w_grant_data;
  logic [SIZE-1:0]             r_item;
  logic [DESTINATION_BITS-1:0] w_grant_idx;
  logic [DESTINATION_BITS-1:0] w_low_idx;
  logic [DESTINATION_BITS-1:0] r_src;
  logic [DESTINATION_BITS-1:0] r_ptr;
  logic                        w_low_valid;
  logic                        w_grant_valid;
  logic                        r_write;
  logic [31:0]                 w_unused_id;

  assign w_unused_id = ID;

  for (genvar k = 0; k < PORT_COUNT; k++) begin : g_slice
    assign w_slice[k] = bus.fifo_push_data[SIZE*k +: SIZE];
  end

  assign w_pending = bus.fifo_push_req ^ r_ack;

  // Descending scan so the last hit is the lowest pending index.
  always_comb begin
    w_low_valid = 1'b0;
    w_low_idx   = '0;
    for (int k = PORT_COUNT - 1; k >= 0; k--) begin
      if (w_pending[k]) begin
        w_low_valid = 1'b1;
        w_low_idx   = DESTINATION_BITS'(k);
      end
    end
  end

`ifdef RX_LOGIC_RR_EN
  logic [DESTINATION_BITS-1:0] w_high_idx;
  logic                        w_high_valid;

  // Lowest pending port above the last grant; otherwise wrap to lowest overall.
  always_comb begin
    w_high_valid = 1'b0;
    w_high_idx   = '0;
    for (int k = PORT_COUNT - 1; k >= 0; k--) begin
      if (w_pending[k] && (DESTINATION_BITS'(k) > r_ptr)) begin
        w_high_valid = 1'b1;
        w_high_idx   = DESTINATION_BITS'(k);
      end
    end
  end

  assign w_grant_idx = w_high_valid ? w_high_idx : w_low_idx;
`else
  logic [DESTINATION_BITS-1:0] w_unused_ptr;

  assign w_unused_ptr = r_ptr;
  assign w_grant_idx  = w_low_idx;
`endif

  assign w_grant_valid = w_low_valid & ~bus.fifo_full;

  always_comb begin
    w_grant_data   = '0;
    w_grant_onehot = '0;
    for (int k = 0; k < PORT_COUNT; k++) begin
      if (w_grant_idx == DESTINATION_BITS'(k)) begin
        w_grant_data      = w_slice[k];
        w_grant_onehot[k] = w_grant_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_item  <= '0;
      r_src   <= '0;
      r_ack   <= '0;
      r_ptr   <= DESTINATION_BITS'(PORT_COUNT - 1);
    end else begin
      r_write <= w_grant_valid;
      if (w_grant_valid) begin
        r_item <= w_grant_data;
        r_src  <= w_grant_idx;
        r_ptr  <= w_grant_idx;
        r_ack  <= r_ack ^ w_grant_onehot;
      end
    end
  end

  assign bus.fifo_push_ack = r_ack;
  assign bus.fifo_write    = r_write;
  assign bus.fifo_item_in  = r_item;
  assign bus.src_port      = r_src;

  a_single_grant : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(w_grant_onehot));
  a_no_grant_when_full : assert property (@(posedge clk) disable iff (!reset)
    bus.fifo_full |-> !w_grant_valid);

endmodule
`default_nettype wire

// File: tb/tb_rx_logic_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rx_logic_2 : scoreboard bench for rx_logic_2 (either arbitration mode). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rx_logic_2;
  localparam int SIZE             = 8;
  localparam int PORT_COUNT       = 5;
  localparam int DESTINATION_BITS = 3;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [PORT_COUNT-1:0] m_ack;
  int   m_ptr;

  always #5 clk = ~clk;

  rx_logic_2_if #(.SIZE(SIZE), .PORT_COUNT(PORT_COUNT), .DESTINATION_BITS(DESTINATION_BITS)) bus ();

  rx_logic_2 #(.ID(7), .SIZE(SIZE), .PORT_COUNT(PORT_COUNT), .DESTINATION_BITS(DESTINATION_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int port, input logic [7:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic offer(input int port, input logic [7:0] data);
    bus.fifo_push_data[port*SIZE +: SIZE] = data;
    bus.fifo_push_req[port] = ~bus.fifo_push_req[port];
  endtask

  // One cycle; output sampled at the falling edge and scored.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.fifo_write) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_write", 32'(bus.fifo_write), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_value("item", 32'(bus.fifo_item_in), 32'(e.data));
        check_value("src_port", 32'(bus.src_port), 32'(e.port));
        m_ack[e.port] = ~m_ack[e.port];
        m_ptr = e.port;
      end
    end
    check_value("ack", 32'(bus.fifo_push_ack), 32'(m_ack));
  endtask

  // Simultaneous offers: expected service order comes from the arbitration rule.
  task automatic batch(input logic [PORT_COUNT-1:0] mask, input logic [7:0] base);
    int start;
    int p;
`ifdef RX_LOGIC_RR_EN
    start = (m_ptr + 1) % PORT_COUNT;
`else
    start = 0;
`endif
    for (int i = 0; i < PORT_COUNT; i++) begin
      p = (start + i) % PORT_COUNT;
      if (mask[p]) push_exp(p, base + 8'(p));
    end
    for (int k = 0; k < PORT_COUNT; k++) begin
      if (mask[k]) offer(k, base + 8'(k));
    end
  endtask

  task automatic burst_all(input logic [7:0] base, input string tag);
    batch('1, base);
    for (int i = 0; i < PORT_COUNT; i++) begin
      tick();
      check_value(tag, 32'(bus.fifo_write), 32'd1);
    end
    tick();
    check_value({tag, "_idle"}, 32'(bus.fifo_write), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_write"}, 32'(bus.fifo_write), 32'd0);
    check_value({tag, "_item"}, 32'(bus.fifo_item_in), 32'd0);
    check_value({tag, "_src"}, 32'(bus.src_port), 32'd0);
    check_value({tag, "_ack"}, 32'(bus.fifo_push_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.fifo_full = 1'b0;
    bus.fifo_push_req = '0;
    bus.fifo_push_data = '0;
    m_ack = '0;
    m_ptr = PORT_COUNT - 1;
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.fifo_push_req  = PORT_COUNT'($urandom);
      bus.fifo_push_data = (PORT_COUNT*SIZE)'({$urandom, $urandom});
      check_outputs_zero("reset");
    end
    bus.fifo_push_req = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_value("idle_write", 32'(bus.fifo_write), 32'd0);
    end

    // Single port with one-cycle latency
    push_exp(2, 8'hA5);
    offer(2, 8'hA5);
    tick();
    check_value("sp_write", 32'(bus.fifo_write), 32'd1);
    check_value("sp_ack2", 32'(bus.fifo_push_ack[2]), 32'd1);
    tick();
    check_value("sp_write_low", 32'(bus.fifo_write), 32'd0);

    // Back-pressure holds requests without loss
    bus.fifo_full = 1'b1;
    batch(5'b01001, 8'h30);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_value("full_no_write", 32'(bus.fifo_write), 32'd0);
    end
    bus.fifo_full = 1'b0;
    tick();
    check_value("unfull_write1", 32'(bus.fifo_write), 32'd1);
    tick();
    check_value("unfull_write2", 32'(bus.fifo_write), 32'd1);
    tick();
    check_value("unfull_idle", 32'(bus.fifo_write), 32'd0);

    // Park the pointer on port 4, then all ports at once
    batch(5'b10000, 8'h44);
    tick();
    tick();
    burst_all(8'h10, "all_a");

    // Park the pointer on port 1, then all ports again
    batch(5'b00010, 8'h41);
    tick();
    tick();
    burst_all(8'h50, "all_b");

`ifndef RX_LOGIC_RR_EN
    // Port 0 re-offers every other cycle and always wins over higher ports
    push_exp(0, 8'h10); push_exp(1, 8'h11); push_exp(0, 8'h20); push_exp(2, 8'h12);
    push_exp(0, 8'h21); push_exp(3, 8'h13); push_exp(0, 8'h22); push_exp(4, 8'h14);
    for (int k = 0; k < PORT_COUNT; k++) offer(k, 8'h10 + 8'(k));
    for (int c = 1; c <= 8; c++) begin
      tick();
      check_value("retoggle_write", 32'(bus.fifo_write), 32'd1);
      if (c == 2 || c == 4 || c == 6) offer(0, 8'h20 + 8'(c / 2 - 1));
    end
    tick();
    check_value("retoggle_idle", 32'(bus.fifo_write), 32'd0);
`endif

    // Asynchronous reset in the middle of a burst
    batch('1, 8'h60);
    tick();
    tick();
    #2 reset = 1'b0;
    #1 check_outputs_zero("async_reset");
    bus.fifo_push_req = '0;
    exp_q.delete();
    m_ack = '0;
    m_ptr = PORT_COUNT - 1;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("post_reset_idle", 32'(bus.fifo_write), 32'd0);
    end

    check_value("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
